// File: rtl/iter_alu.sv
// Iterative ALU: single-cycle logic/arith ops, bit-serial shifts, shift-and-add MUL.
// Define ITER_ALU_MUL_EN to build the multiplier; otherwise 1010 is illegal.
module iter_alu #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   aluctrl,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] result,
  output logic         zero
);

  localparam int lw = $clog2(n);

  localparam logic [3:0] op_and = 4'b0000;
  localparam logic [3:0] op_or  = 4'b0001;
  localparam logic [3:0] op_add = 4'b0010;
  localparam logic [3:0] op_sub = 4'b0110;
  localparam logic [3:0] op_slt = 4'b0111;
  localparam logic [3:0] op_nor = 4'b1100;
  localparam logic [3:0] op_sll = 4'b1000;
  localparam logic [3:0] op_srl = 4'b1001;
  localparam logic [3:0] op_mul = 4'b1010;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t       state_q;
  state_t       state_d;
  logic [3:0]   op_q;
  logic [n-1:0] res_q;
  logic [lw:0]  cnt_q;

`ifdef ITER_ALU_MUL_EN
  logic [n-1:0] mcand_q;
  logic [n-1:0] mplier_q;
`endif

  logic          accept;
  logic          is_shift;
  logic          is_mul;
  logic          iter;
  logic          last;
  logic          slt;
  logic [lw-1:0] shamt;
  logic [n-1:0]  quick;

  assign accept   = (state_q == IDLE) && in_valid;
  assign shamt    = b[lw-1:0];
  assign is_shift = (aluctrl == op_sll) || (aluctrl == op_srl);
`ifdef ITER_ALU_MUL_EN
  assign is_mul   = (aluctrl == op_mul);
`else
  assign is_mul   = 1'b0;
`endif
  assign iter     = is_mul || (is_shift && (shamt != '0));
  assign last     = (cnt_q == (lw+1)'(1));
  assign slt      = $signed(a) < $signed(b);

  // Shifts by zero fall through here as a plain copy of a.
  always_comb begin
    quick = '0;
    case (aluctrl)
      op_and:  quick = a & b;
      op_or:   quick = a | b;
      op_add:  quick = a + b;
      op_sub:  quick = a - b;
      op_slt:  quick = {{(n-1){1'b0}}, slt};
      op_nor:  quick = ~(a | b);
      op_sll:  quick = a;
      op_srl:  quick = a;
      default: quick = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = iter ? BUSY : DONE;
        end
      end
      BUSY: begin
        if (last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q  <= '0;
      res_q <= '0;
      cnt_q <= '0;
`ifdef ITER_ALU_MUL_EN
      mcand_q  <= '0;
      mplier_q <= '0;
`endif
    end else if (accept) begin
      op_q  <= aluctrl;
      res_q <= is_mul ? '0 : quick;
      cnt_q <= is_mul ? (lw+1)'(n) : {1'b0, shamt};
`ifdef ITER_ALU_MUL_EN
      mcand_q  <= a;
      mplier_q <= b;
`endif
    end else if (state_q == BUSY) begin
      cnt_q <= cnt_q - (lw+1)'(1);
      case (op_q)
        op_sll: res_q <= res_q << 1;
        op_srl: res_q <= res_q >> 1;
`ifdef ITER_ALU_MUL_EN
        op_mul: begin
          if (mplier_q[0]) begin
            res_q <= res_q + mcand_q;
          end
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
        end
`endif
        default: res_q <= res_q;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = res_q;
  assign zero      = out_valid && (res_q == '0);

endmodule

// File: doc/iter_alu.md
ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 Parameter: n, default 32, operand/result width in bits (power of two, >= 8).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  operation request present.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 aluctrl  input  4  ALU control code from the ALU decoder.
REQ-007 a  input  n  operand A.
REQ-008 b  input  n  operand B; for shifts, b[log2(n)-1:0] is the shift amount.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer takes result this cycle.
REQ-011 result  output  n  operation result.
REQ-012 zero  output  1  high when result == 0, valid while out_valid is high.

Function
REQ-013 Codes SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed, result 1/0), 1100 NOR, 1000 SLL, 1001 SRL, 1010 MUL; all other codes illegal.
REQ-014 FSM SHALL have states IDLE, BUSY, DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 In IDLE with in_valid=1, the block SHALL capture aluctrl, a, b on that edge (accept).
REQ-016 AND/OR/ADD/SUB/SLT/NOR and illegal codes SHALL go IDLE->DONE on accept; out_valid high the cycle after accept.
REQ-017 SLL/SRL with shift amount k>0 SHALL go IDLE->BUSY, shift one bit per cycle, enter DONE after k BUSY cycles; k=0 SHALL go directly to DONE with result=a.
REQ-018 MUL SHALL use shift-and-add, exactly n BUSY cycles, result = low n bits of a*b (unsigned).
REQ-019 ADD/SUB/MUL SHALL wrap modulo 2^n; no overflow flag.
REQ-020 Illegal codes SHALL produce result 0 and zero=1.
REQ-021 In DONE, result and zero SHALL hold stable until out_ready=1; on out_ready=1 the block SHALL return to IDLE next cycle.
REQ-022 No new request SHALL be accepted in the cycle out_ready is sampled (one idle cycle between results minimum).
REQ-023 Inputs aluctrl/a/b SHALL be ignored outside the accept cycle; changes during BUSY SHALL not affect result.
REQ-024 in_valid while in BUSY or DONE SHALL be ignored (no capture, no error).

Reset
REQ-025 reset=1 SHALL immediately force state IDLE, in_ready=1, out_valid=0, result=0, zero=0, counters and operand registers 0.
REQ-026 Reset asserted mid-BUSY or in DONE SHALL abandon the operation; no result is produced after reset release.
REQ-027 First accept SHALL be possible on the first rising edge after reset deasserts.

Configuration
REQ-028 Macro ITER_ALU_MUL_EN: when defined, MUL (1010) SHALL behave per REQ-018.
REQ-029 When ITER_ALU_MUL_EN is undefined, no multiplier datapath SHALL be built and 1010 SHALL be treated as illegal per REQ-016/REQ-020.

Verification
REQ-030 ADD a=0x00000005 b=0x00000003 -> out_valid next cycle, result=0x00000008, zero=0; SUB same operands -> 0x00000002.
REQ-031 SLT a=0xFFFFFFFF b=0x00000001 -> result=1; SUB a=b=0x1234 -> result=0, zero=1.
REQ-032 SLL a=0x00000001 b=5 -> out_valid 6 cycles after accept, result=0x00000020; SRL a=0x80000000 b=0 -> result=0x80000000, one-cycle latency.
REQ-033 MUL a=0x00010001 b=0x00010001 -> out_valid after 33 cycles (n=32), result=0x00020001 with macro; result=0, one-cycle latency without.
REQ-034 Hold out_ready=0 for 4 cycles in DONE while toggling in_valid/a/b -> result stable, in_ready=0, no capture; out_ready=1 -> IDLE next cycle.
REQ-035 Assert reset 3 cycles into an SLL by 10 -> outputs reset immediately, no out_valid afterwards, next ADD completes normally.
